// File: rtl/coffee_pkg.sv
// Shared constants, FSM state type and valve decode for the coffee dispense sequencer.
package coffee_pkg;

  localparam logic [2:0] ESPRESSO   = 3'd0;
  localparam logic [2:0] WITH_MILK  = 3'd1;
  localparam logic [2:0] CAPPUCCINO = 3'd2;
  localparam logic [2:0] MOCACCINO  = 3'd3;

  localparam logic [2:0] WATER           = 3'd0;
  localparam logic [2:0] COFFEE          = 3'd1;
  localparam logic [2:0] MILK            = 3'd2;
  localparam logic [2:0] CHOCOLATE       = 3'd3;
  localparam logic [2:0] SUGAR           = 3'd4;
  localparam logic [2:0] LAST_INGREDIENT = SUGAR;

  localparam int unsigned VALVE_WATER     = 0;
  localparam int unsigned VALVE_COFFEE    = 1;
  localparam int unsigned VALVE_MILK      = 2;
  localparam int unsigned VALVE_CHOCOLATE = 3;
  localparam int unsigned VALVE_SUGAR     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISPENSE,
    S_NEXT,
    S_DONE
  } fsm_t;

  function automatic logic [4:0] valve_onehot(input logic [2:0] idx);
    logic [4:0] v;
    v = '0;
    case (idx)
      WATER:     v[VALVE_WATER]     = 1'b1;
      COFFEE:    v[VALVE_COFFEE]    = 1'b1;
      MILK:      v[VALVE_MILK]      = 1'b1;
      CHOCOLATE: v[VALVE_CHOCOLATE] = 1'b1;
      SUGAR:     v[VALVE_SUGAR]     = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coffee_dispense_sequencer_unit_tick_gen.sv
// Tick prescaler: counts 0..TICKS_PER_UNIT-1 while enabled, pulses tc on the terminal count.
module unit_tick_gen #(
  parameter int unsigned TICKS_PER_UNIT = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned W = $clog2(TICKS_PER_UNIT);
  localparam logic [W-1:0] LAST = W'(TICKS_PER_UNIT - 1);

  logic [W-1:0] cnt;

  assign tc = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/coffee_dispense_sequencer.sv
// Brew sequencer: walks ingredients 0..4, opening each valve for the looked-up number of time units.
module coffee_dispense_sequencer
  import coffee_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] coffee_sel,
  input  logic [1:0] ingredient_time,
  output logic [2:0] coffee_type,
  output logic [2:0] state,
  output logic [4:0] valve,
  output logic       busy,
  output logic       done,
  output logic       reject
);

  fsm_t       fsm_q, fsm_d;
  logic [2:0] idx_d;
  logic [2:0] type_d;
  logic [1:0] unit_q, unit_d;
  logic [4:0] valve_d;
  logic       busy_d, done_d, reject_d;
  logic       tick_tc;

  unit_tick_gen #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (fsm_q == S_LOAD),
    .enable(fsm_q == S_DISPENSE),
    .tc    (tick_tc)
  );

  always_comb begin
    fsm_d    = fsm_q;
    idx_d    = state;
    type_d   = coffee_type;
    unit_d   = unit_q;
    reject_d = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) begin
          if (coffee_sel inside {ESPRESSO, WITH_MILK, CAPPUCCINO, MOCACCINO}) begin
            type_d = coffee_sel;
            fsm_d  = S_LOAD;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // zero-time ingredients are skipped in place, without a NEXT cycle
        if (ingredient_time == 2'd0) begin
          if (state == LAST_INGREDIENT) begin
            fsm_d = S_DONE;
            idx_d = '0;
          end else begin
            idx_d = state + 3'd1;
          end
        end else begin
          unit_d = ingredient_time;
          fsm_d  = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        if (tick_tc) begin
          unit_d = unit_q - 2'd1;
          if (unit_q == 2'd1) fsm_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (state == LAST_INGREDIENT) begin
          fsm_d = S_DONE;
          idx_d = '0;
        end else begin
          idx_d = state + 3'd1;
          fsm_d = S_LOAD;
        end
      end
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase

    // outputs are registered from the next state so they line up with the FSM state
    valve_d = (fsm_d == S_DISPENSE) ? valve_onehot(idx_d) : '0;
    busy_d  = (fsm_d == S_LOAD) || (fsm_d == S_DISPENSE) || (fsm_d == S_NEXT);
    done_d  = (fsm_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      state       <= '0;
      coffee_type <= '0;
      unit_q      <= '0;
      valve       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      reject      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state       <= idx_d;
      coffee_type <= type_d;
      unit_q      <= unit_d;
      valve       <= valve_d;
      busy        <= busy_d;
      done        <= done_d;
      reject      <= reject_d;
    end
  end

endmodule

// File: doc/coffee_dispense_sequencer.md
Name: coffee_dispense_sequencer

Overview:
Brew sequencer FSM that sits in front of the per-coffee ingredient-time lookup.
- On a start request it latches the selected coffee type and walks ingredient indices 0..4 (water, coffee, milk, chocolate, sugar).
- For each index it presents the index to the lookup and reads back the ingredient time in units.
- It opens the matching valve for exactly that many time units, then reports completion.

Parameters:
TICKS_PER_UNIT, 50_000_000, clk cycles per time unit (1 s at 50 MHz); bench overrides to 4; legal range >= 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  brew request, sampled only in IDLE
coffee_sel  input  3  requested type: 0 espresso, 1 with milk, 2 cappuccino, 3 mocaccino; 4..7 illegal
ingredient_time  input  2  time units for (coffee_type, state), from the combinational lookup
coffee_type  output  3  latched type driven to the lookup
state  output  3  current ingredient index driven to the lookup, 0..4
valve  output  5  one-hot valve enable: bit0 water, bit1 coffee, bit2 milk, bit3 chocolate, bit4 sugar
busy  output  1  high from LOAD through the final NEXT
done  output  1  one-cycle completion pulse
reject  output  1  one-cycle pulse when start arrives with an illegal coffee_sel

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - coffee_type=0, state=0, valve=0, busy=0, done=0, reject=0.
  - Tick and unit counters clear.
  - Valves close immediately, even mid-dispense. No resume after reset release.
- All outputs are registered. valve is a function of the FSM state and index only, never of the inputs.
- FSM states: IDLE, LOAD, DISPENSE, NEXT, DONE.
- IDLE:
  - busy=0, state=0.
  - start=1 with coffee_sel<=3: latch coffee_sel into coffee_type, index=0, go to LOAD.
  - start=1 with coffee_sel>=4: reject=1 for the next cycle, stay in IDLE, coffee_type unchanged.
- LOAD:
  - busy=1, valve=0. Samples ingredient_time; the lookup is combinational on registered outputs, so it is valid in this cycle.
  - ingredient_time=0: ingredient is skipped, with no NEXT cycle. If index=4, go to DONE; else index+1 and stay in LOAD.
  - ingredient_time>0: unit counter = ingredient_time, tick counter = 0, go to DISPENSE.
- DISPENSE:
  - valve[index]=1; all other bits 0.
  - Tick counter counts 0..TICKS_PER_UNIT-1. At the terminal count it wraps to 0 and the unit counter decrements.
  - At the terminal count with unit counter=1, go to NEXT.
  - Net effect: valve[index] is high for exactly ingredient_time*TICKS_PER_UNIT consecutive cycles.
- NEXT: valve=0 (one-cycle break-before-make). If index=4, go to DONE; else index+1 and go to LOAD.
- DONE: busy=0, done=1 for this one cycle, state returns to 0, go to IDLE.
- Busy duration = 5 (LOAD cycles) + sum(times)*TICKS_PER_UNIT + N_nonzero (NEXT cycles).
- start while busy or in DONE: ignored, not queued. coffee_sel changes after acceptance: no effect.
- Back-to-back brews: a start held high in the IDLE cycle after DONE is accepted normally.
- ingredient_time is trusted as-is. An index >4 is unreachable; the index counter saturates by construction.
- Arithmetic widths:
  - Unit counter: 2 bits.
  - Tick counter: $clog2(TICKS_PER_UNIT) bits, compared with TICKS_PER_UNIT-1 (no overflow past terminal).

Decomposition:
- Package coffee_pkg:
  - Coffee-type constants (ESPRESSO=0, WITH_MILK=1, CAPPUCCINO=2, MOCACCINO=3).
  - Ingredient index constants (WATER=0 .. SUGAR=4), LAST_INGREDIENT=4.
  - Enum typedef for the FSM states.
  - Valve bit positions.
- One sub-module, unit_tick_gen:
  - Parameterised tick prescaler with clear and enable inputs and a terminal-count pulse output.
  - Cleared in LOAD, enabled in DISPENSE.
- The ingredient-time lookup stays an external instance, wired at the top level.

Test Plan:
- TICKS_PER_UNIT=4, lookup connected, start with coffee_sel=0 (espresso) -> valve 5'b00001 for 8 cycles, then 0 for 2 cycles (NEXT, LOAD), then 5'b00010 for 12 cycles. Milk and chocolate are skipped with no valve activity. Then 5'b10000 for 4 cycles. busy high for 32 cycles, then done=1 for one cycle.
- coffee_sel=3 (mocaccino) -> valve pattern water 4, coffee 4, milk 4, chocolate 8, sugar 4 cycles, each separated by 2 closed cycles; busy high for 34 cycles; single done pulse.
- start with coffee_sel=5 -> reject=1 for one cycle; busy, valve and coffee_type unchanged; no done.
- Second start (coffee_sel=1) pulsed during a busy espresso brew -> ignored; coffee_type stays 0; exactly one done pulse.
- rst_n driven low mid-DISPENSE of coffee -> valve=0 and busy=0 asynchronously, before the next clk edge. After release the FSM sits in IDLE and needs a new start.
- start held high continuously with coffee_sel=2 -> brew restarts in the IDLE cycle right after each done. Cappuccino busy = 5+24+4 = 33 cycles per brew.
